// File: rtl/fp_add_scheduler.sv
// Two-requester floating-point adder with round-robin arbitration and a
// multi-cycle align/add/normalize datapath; one operation in flight at a time.
module fp_add_scheduler #(
  parameter logic [7:0] EXP_MAX = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [32:0] req0_a,
  input  logic [32:0] req0_b,
  input  logic [32:0] req1_a,
  input  logic [32:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [32:0] res_data,
  output logic [31:0] res_ieee,
  output logic        res_id,
  output logic        res_ovf
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  st_q, st_d;
  logic        ptr_q, ptr_d;
  logic        id_q, id_d;
  logic        a_s_q, a_s_d, b_s_q, b_s_d;
  logic [7:0]  a_e_q, a_e_d, b_e_q, b_e_d;
  logic [23:0] a_m_q, a_m_d, b_m_q, b_m_d;
  logic        w_s_q, w_s_d;
  logic [7:0]  w_e_q, w_e_d;
  logic [24:0] w_m_q, w_m_d;
  logic [32:0] rdata_q, rdata_d;
  logic        rid_q, rid_d;
  logic        rovf_q, rovf_d;
  logic [7:0]  diff;
  logic        gnt_any;
  logic        gnt_id;

  assign gnt_any = req0_valid | req1_valid;
  // Contention goes to the pointer; otherwise whichever port is asking.
  assign gnt_id  = (req0_valid & req1_valid) ? ptr_q : req1_valid;

  assign req0_ready = rst_n & (st_q == IDLE) & gnt_any & ~gnt_id;
  assign req1_ready = rst_n & (st_q == IDLE) & gnt_any & gnt_id;

  assign res_valid = (st_q == DONE);
  assign res_data  = rdata_q;
  assign res_ieee  = {rdata_q[32], rdata_q[31:24], rdata_q[22:0]};
  assign res_id    = rid_q;
  assign res_ovf   = rovf_q;

  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_s_d   = a_s_q;
    a_e_d   = a_e_q;
    a_m_d   = a_m_q;
    b_s_d   = b_s_q;
    b_e_d   = b_e_q;
    b_m_d   = b_m_q;
    w_s_d   = w_s_q;
    w_e_d   = w_e_q;
    w_m_d   = w_m_q;
    rdata_d = rdata_q;
    rid_d   = rid_q;
    rovf_d  = rovf_q;
    diff    = 8'd0;
    case (st_q)
      IDLE: begin
        if (gnt_any) begin
          st_d  = ALIGN;
          ptr_d = ~gnt_id;
          id_d  = gnt_id;
          {a_s_d, a_e_d, a_m_d} = gnt_id ? req1_a : req0_a;
          {b_s_d, b_e_d, b_m_d} = gnt_id ? req1_b : req0_b;
        end
      end
      ALIGN: begin
        st_d = ADD;
        if (a_e_q >= b_e_q) begin
          diff  = a_e_q - b_e_q;
          w_e_d = a_e_q;
          b_m_d = (diff >= 8'd25) ? 24'd0 : (b_m_q >> diff);
        end else begin
          diff  = b_e_q - a_e_q;
          w_e_d = b_e_q;
          a_m_d = (diff >= 8'd25) ? 24'd0 : (a_m_q >> diff);
        end
      end
      ADD: begin
        st_d = NORM;
        if (a_s_q == b_s_q) begin
          w_m_d = {1'b0, a_m_q} + {1'b0, b_m_q};
          w_s_d = a_s_q;
        end else if (a_m_q > b_m_q) begin
          w_m_d = {1'b0, a_m_q} - {1'b0, b_m_q};
          w_s_d = a_s_q;
        end else if (b_m_q > a_m_q) begin
          w_m_d = {1'b0, b_m_q} - {1'b0, a_m_q};
          w_s_d = b_s_q;
        end else begin
          w_m_d = 25'd0;
          w_s_d = 1'b0;
        end
      end
      NORM: begin
        if (w_m_q[24]) begin
          st_d  = DONE;
          rid_d = id_q;
          if (w_e_q == EXP_MAX) begin
            rovf_d  = 1'b1;
            rdata_d = {w_s_q, EXP_MAX, 24'hFFFFFF};
          end else begin
            rovf_d  = 1'b0;
            rdata_d = {w_s_q, w_e_q + 8'd1, w_m_q[24:1]};
          end
        end else if (w_m_q == 25'd0) begin
          st_d    = DONE;
          rid_d   = id_q;
          rovf_d  = 1'b0;
          rdata_d = 33'd0;
        end else if (w_m_q[23] || (w_e_q == 8'd0)) begin
          // Exponent floor reached: keep the denormal as is.
          st_d    = DONE;
          rid_d   = id_q;
          rovf_d  = 1'b0;
          rdata_d = {w_s_q, w_e_q, w_m_q[23:0]};
        end else begin
          w_m_d = {w_m_q[23:0], 1'b0};
          w_e_d = w_e_q - 8'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      a_s_q   <= 1'b0;
      a_e_q   <= 8'd0;
      a_m_q   <= 24'd0;
      b_s_q   <= 1'b0;
      b_e_q   <= 8'd0;
      b_m_q   <= 24'd0;
      w_s_q   <= 1'b0;
      w_e_q   <= 8'd0;
      w_m_q   <= 25'd0;
      rdata_q <= 33'd0;
      rid_q   <= 1'b0;
      rovf_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_s_q   <= a_s_d;
      a_e_q   <= a_e_d;
      a_m_q   <= a_m_d;
      b_s_q   <= b_s_d;
      b_e_q   <= b_e_d;
      b_m_q   <= b_m_d;
      w_s_q   <= w_s_d;
      w_e_q   <= w_e_d;
      w_m_q   <= w_m_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      rovf_q  <= rovf_d;
    end
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: vector table, scoreboard of accepted operations,
// and directed sequences for arbitration, result hold, cancel and reset.
module tb_fp_add_scheduler;

  typedef struct {
    logic [32:0] data;
    logic        ovf;
    logic        id;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [32:0] a;
    logic [32:0] b;
    logic [32:0] data;
    logic        ovf;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [32:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        res_valid;
  logic        res_ready;
  logic [32:0] res_data;
  logic [31:0] res_ieee;
  logic        res_id;
  logic        res_ovf;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t port_exp[2];
  vec_t vt[11];

  fp_add_scheduler #(.EXP_MAX(8'hFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ieee  (res_ieee),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] mk(input logic s, input logic [7:0] e, input logic [23:0] m);
    return {s, e, m};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  // Scoreboard: push on accept pulse, compare on result, pop on handshake.
  initial begin
    exp_t e;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        seen = 1'b0;
      end else begin
        if (req0_ready || req1_ready) begin
          chk("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
          chk("ready_while_busy", 64'((q.size() != 0) || res_valid), 64'd0);
          chk("ready_without_valid", 64'(req1_ready ? req1_valid : req0_valid), 64'd1);
          e     = port_exp[req1_ready ? 1 : 0];
          e.id  = req1_ready;
          e.acc = cyc;
          q.push_back(e);
        end
        if (res_valid) begin
          if (q.size() == 0) begin
            timeout_fail("unexpected_result");
          end else begin
            e = q[0];
            if (!seen) begin
              chk("latency", 64'(cyc - e.acc), 64'(e.lat));
              chk("res_data", 64'(res_data), 64'(e.data));
              chk("res_ieee", 64'(res_ieee), 64'({e.data[32], e.data[31:24], e.data[22:0]}));
              chk("res_ovf", 64'(res_ovf), 64'(e.ovf));
              chk("res_id", 64'(res_id), 64'(e.id));
              seen = 1'b1;
            end else begin
              chk("hold_outputs", 64'({res_ovf, res_id, res_data}), 64'({e.ovf, e.id, e.data}));
            end
            if (res_ready) begin
              void'(q.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic wait_any(input int budget, output int port);
    port = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (req0_ready) begin
        port = 0;
        break;
      end
      if (req1_ready) begin
        port = 1;
        break;
      end
    end
  endtask

  task automatic set_port(input int p, input vec_t v);
    port_exp[p] = '{data: v.data, ovf: v.ovf, id: 1'(p), lat: v.lat, acc: 0};
    if (p == 0) begin
      req0_a = v.a;
      req0_b = v.b;
    end else begin
      req1_a = v.a;
      req1_b = v.b;
    end
  endtask

  // Present one operation on port p, wait for its accept, then drop valid.
  task automatic drive(input int p, input vec_t v);
    int got;
    @(posedge clk);
    #1;
    set_port(p, v);
    if (p == 0) req0_valid = 1'b1;
    else        req1_valid = 1'b1;
    wait_any(30, got);
    if (got < 0) timeout_fail("accept_wait");
    else         chk("grant_port", 64'(got), 64'(p));
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if ((q.size() == 0) && !res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("drain_wait");
  endtask

  // Both ports request together; expect port 0 first, then port 1.
  task automatic both_ports(input string tag);
    int got;
    @(posedge clk);
    #1;
    set_port(0, vt[0]);
    set_port(1, vt[1]);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_any(30, got);
    chk({tag, "_first"}, 64'(got), 64'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_any(30, got);
    chk({tag, "_second"}, 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    drain(40);
  endtask

  initial begin
    int  got;
    bit  ok;
    vt[0]  = '{a: mk(0, 8'h80, 24'h800000), b: mk(0, 8'h80, 24'h800000),
               data: mk(0, 8'h81, 24'h800000), ovf: 1'b0, lat: 4};
    vt[1]  = '{a: mk(0, 8'h82, 24'h800000), b: mk(0, 8'h80, 24'h800000),
               data: mk(0, 8'h82, 24'hA00000), ovf: 1'b0, lat: 4};
    vt[2]  = '{a: mk(0, 8'h80, 24'h800000), b: mk(1, 8'h80, 24'h400000),
               data: mk(0, 8'h7F, 24'h800000), ovf: 1'b0, lat: 5};
    vt[3]  = '{a: mk(0, 8'h80, 24'hC00000), b: mk(1, 8'h80, 24'hC00000),
               data: 33'd0, ovf: 1'b0, lat: 4};
    vt[4]  = '{a: mk(0, 8'hFF, 24'h800000), b: mk(0, 8'hFF, 24'h800000),
               data: mk(0, 8'hFF, 24'hFFFFFF), ovf: 1'b1, lat: 4};
    vt[5]  = '{a: mk(0, 8'h80, 24'h400000), b: mk(1, 8'h80, 24'hC00000),
               data: mk(1, 8'h80, 24'h800000), ovf: 1'b0, lat: 4};
    vt[6]  = '{a: mk(0, 8'h02, 24'h100000), b: mk(0, 8'h02, 24'h000000),
               data: mk(0, 8'h00, 24'h400000), ovf: 1'b0, lat: 6};
    vt[7]  = '{a: mk(0, 8'h90, 24'h800000), b: mk(0, 8'h70, 24'hFFFFFF),
               data: mk(0, 8'h90, 24'h800000), ovf: 1'b0, lat: 4};
    vt[8]  = '{a: mk(0, 8'h97, 24'h800000), b: mk(0, 8'h80, 24'h800000),
               data: mk(0, 8'h97, 24'h800001), ovf: 1'b0, lat: 4};
    vt[9]  = '{a: mk(1, 8'h10, 24'hC00000), b: mk(1, 8'h10, 24'hC00000),
               data: mk(1, 8'h11, 24'hC00000), ovf: 1'b0, lat: 4};
    vt[10] = '{a: mk(0, 8'h80, 24'h800000), b: mk(0, 8'h82, 24'h800000),
               data: mk(0, 8'h82, 24'hA00000), ovf: 1'b0, lat: 4};

    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req1_a = '0;
    req1_b = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_readies", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_ieee", 64'(res_ieee), 64'd0);
    chk("rst_id_ovf", 64'({res_id, res_ovf}), 64'd0);
    rst_n = 1'b1;

    both_ports("arb");

    for (int i = 0; i < 11; i++) begin
      drive(i % 2, vt[i]);
      drain(40);
    end

    // Consumer stalls for 5 cycles while port 1 waits.
    res_ready = 1'b0;
    drive(0, vt[2]);
    set_port(1, vt[3]);
    req1_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("hold_wait");
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_no_ready", 64'(req1_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_any(30, got);
    chk("hold_next_port", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    drain(40);

    // Port 1 withdraws before it is ever granted.
    drive(0, vt[6]);
    req1_a = vt[9].a;
    req1_b = vt[9].b;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req1_valid = 1'b0;
    drain(40);
    repeat (6) @(negedge clk);
    #1;
    chk("cancel_quiet", 64'({res_valid, req0_ready, req1_ready}), 64'd0);

    // Reset lands while the operation is still normalizing.
    drive(0, vt[6]);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_readies", 64'({req0_ready, req1_ready}), 64'd0);
    chk("midrst_res_data", 64'(res_data), 64'd0);
    chk("midrst_res_ieee", 64'(res_ieee), 64'd0);
    chk("midrst_id_ovf", 64'({res_id, res_ovf}), 64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("midrst_no_result", 64'(res_valid), 64'd0);
    both_ports("rstarb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
